// File: rtl/mem_pkg.sv
// Shared encodings for the two-port ram arbiter: transfer lengths, read/write
// polarity, requester ids and FSM states.
package mem_pkg;
  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;
endpackage

// File: rtl/mem_align_check.sv
// Legality of a ram access: only the two low address bits matter for alignment.
module mem_align_check
  import mem_pkg::*;
(
  input  logic [1:0] len,
  input  logic [1:0] addr,
  output logic       legal
);
  always_comb begin
    legal = 1'b0;
    case (len)
      LEN_BYTE: legal = 1'b1;
      LEN_HALF: legal = ~addr[0];
      LEN_WORD: legal = (addr == 2'b00);
      default:  legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one ram between instruction fetch (I) and the
// load/store unit (D); sequences enable/mfc with a completion timeout.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_len,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              ram_enable,
  output logic              ram_read_write,
  output logic [1:0]        ram_data_length,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  input  logic              ram_mfc
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              port_q, port_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              ram_enable_q, ram_enable_d;
  logic              ram_rw_q, ram_rw_d;
  logic [1:0]        ram_len_q, ram_len_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              i_ready_q, i_ready_d, i_err_q, i_err_d;
  logic              d_ready_q, d_ready_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  // Candidate request as it would be latched at grant
  logic              gnt_port, sel_rw, sel_legal;
  logic [1:0]        sel_len;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    gnt_port  = (i_req && d_req) ? ~last_grant_q : (d_req ? PORT_D : PORT_I);
    sel_rw    = (gnt_port == PORT_D) ? d_rw    : RW_READ;
    sel_len   = (gnt_port == PORT_D) ? d_len   : LEN_WORD;
    sel_addr  = (gnt_port == PORT_D) ? d_addr  : i_addr;
    sel_wdata = (gnt_port == PORT_D) ? d_wdata : '0;
  end

  mem_align_check u_align (
    .len   (sel_len),
    .addr  (sel_addr[1:0]),
    .legal (sel_legal)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    timer_d      = timer_q;
    ram_enable_d = ram_enable_q;
    ram_rw_d     = ram_rw_q;
    ram_len_d    = ram_len_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    i_err_d      = i_err_q;
    d_err_d      = d_err_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          last_grant_d = gnt_port;
          port_d       = gnt_port;
          rdata_d      = '0;
          if (sel_legal) begin
            ram_enable_d = 1'b1;
            ram_rw_d     = sel_rw;
            ram_len_d    = sel_len;
            ram_addr_d   = sel_addr;
            ram_wdata_d  = sel_wdata;
            timer_d      = '0;
            err_d        = 1'b0;
            state_d      = ST_ACCESS;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        timer_d = timer_q + 1'b1;
        if (ram_mfc) begin
          rdata_d      = (ram_rw_q == RW_READ) ? ram_data_out : '0;
          ram_enable_d = 1'b0;
          state_d      = ST_RELEASE;
        end else if (timer_q == TO_LAST) begin
          ram_enable_d = 1'b0;
          err_d        = 1'b1;
          state_d      = ST_RELEASE;
        end
      end
      // Wait for the ram to withdraw mfc so the next access starts clean
      ST_RELEASE: begin
        if (!ram_mfc) state_d = ST_RESP;
      end
      default: begin
        if (port_q == PORT_D) begin
          d_ready_d = 1'b1;
          d_rdata_d = rdata_q;
          d_err_d   = err_q;
        end else begin
          i_ready_d = 1'b1;
          i_rdata_d = rdata_q;
          i_err_d   = err_q;
        end
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_I;
      port_q       <= PORT_I;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      timer_q      <= '0;
      ram_enable_q <= 1'b0;
      ram_rw_q     <= 1'b0;
      ram_len_q    <= 2'd0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      timer_q      <= timer_d;
      ram_enable_q <= ram_enable_d;
      ram_rw_q     <= ram_rw_d;
      ram_len_q    <= ram_len_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_err_q      <= i_err_d;
      d_err_q      <= d_err_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign i_ready         = i_ready_q;
  assign i_rdata         = i_rdata_q;
  assign i_err           = i_err_q;
  assign d_ready         = d_ready_q;
  assign d_rdata         = d_rdata_q;
  assign d_err           = d_err_q;
  assign ram_enable      = ram_enable_q;
  assign ram_read_write  = ram_rw_q;
  assign ram_data_length = ram_len_q;
  assign ram_address     = ram_addr_q;
  assign ram_data_in     = ram_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte ram model whose mfc delay
// can be stretched or suppressed.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_rw;
  logic [8:0]  i_addr, d_addr;
  logic [1:0]  d_len;
  logic [31:0] d_wdata;
  logic        i_ready, i_err, d_ready, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        ram_enable, ram_read_write, ram_mfc;
  logic [1:0]  ram_data_length;
  logic [8:0]  ram_address;
  logic [31:0] ram_data_in, ram_data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_rw(d_rw), .d_len(d_len), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .ram_enable(ram_enable), .ram_read_write(ram_read_write),
    .ram_data_length(ram_data_length), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .ram_mfc(ram_mfc)
  );

  // Ram model: big-endian byte store, right-aligned sub-word data; mfc falls
  // combinationally with enable.
  logic [7:0]  mem [0:511];
  int          mfc_dly = 1;
  logic        mfc_off = 1'b0;
  int          rcnt = 0;
  logic        rdone = 1'b0;
  logic [31:0] rdout = 32'h0;
  assign ram_mfc      = ram_enable & rdone;
  assign ram_data_out = rdout;

  always @(posedge clk) begin
    if (!ram_enable) begin
      rcnt  <= 0;
      rdone <= 1'b0;
    end else if (!rdone && !mfc_off) begin
      rcnt <= rcnt + 1;
      if (rcnt + 1 >= mfc_dly) begin
        rdone <= 1'b1;
        if (ram_read_write) begin
          case (ram_data_length)
            2'd0:    rdout <= {24'h0, mem[ram_address]};
            2'd1:    rdout <= {16'h0, mem[ram_address], mem[9'(ram_address + 9'd1)]};
            default: rdout <= {mem[ram_address], mem[9'(ram_address + 9'd1)],
                               mem[9'(ram_address + 9'd2)], mem[9'(ram_address + 9'd3)]};
          endcase
        end else begin
          case (ram_data_length)
            2'd0: mem[ram_address] <= ram_data_in[7:0];
            2'd1: begin
              mem[ram_address]              <= ram_data_in[15:8];
              mem[9'(ram_address + 9'd1)]   <= ram_data_in[7:0];
            end
            default: begin
              mem[ram_address]              <= ram_data_in[31:24];
              mem[9'(ram_address + 9'd1)]   <= ram_data_in[23:16];
              mem[9'(ram_address + 9'd2)]   <= ram_data_in[15:8];
              mem[9'(ram_address + 9'd3)]   <= ram_data_in[7:0];
            end
          endcase
        end
      end
    end
  end

  // Drivers: called at posedge+1; cyc counts edges until ready is seen (100 = gave up)
  task automatic d_txn(input logic rw, input logic [1:0] len, input logic [8:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int cyc, output int en_cyc, output logic [1:0] seen_len);
    d_rw = rw; d_len = len; d_addr = addr; d_wdata = wd; d_req = 1'b1;
    cyc = 0; en_cyc = 0; seen_len = 2'd3;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (ram_enable) begin en_cyc++; seen_len = ram_data_length; end
    end while (!d_ready && cyc < 100);
    rd = d_rdata; er = d_err; d_req = 1'b0;
  endtask

  task automatic i_txn(input logic [8:0] addr, output logic [31:0] rd, output logic er,
                       output int cyc, output int en_cyc);
    i_addr = addr; i_req = 1'b1;
    cyc = 0; en_cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (ram_enable) en_cyc++;
    end while (!i_ready && cyc < 100);
    rd = i_rdata; er = i_err; i_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_rw = 1'b1; d_len = 2'd0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    #12;
    total++;
    if ({ram_enable, i_ready, d_ready, i_err, d_err, ram_read_write} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000000",
                      {ram_enable, i_ready, d_ready, i_err, d_err, ram_read_write});
    end
    total++;
    if ({i_rdata, d_rdata, ram_data_in, ram_address, ram_data_length} !== 107'b0) begin
      bad++; $display("FAIL reset_data got nonzero i_rdata=%h d_rdata=%h addr=%h",
                      i_rdata, d_rdata, ram_address);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_fetch;
    logic [31:0] rd; logic er; int cyc, en; logic [1:0] sl;
    d_txn(1'b0, 2'd2, 9'h004, 32'h11223344, rd, er, cyc, en, sl);
    total++;
    if (er !== 1'b0 || cyc != 5) begin
      bad++; $display("FAIL preload_write err=%b cyc=%0d exp err=0 cyc=5", er, cyc);
    end
    mfc_dly = 1;
    i_txn(9'h004, rd, er, cyc, en);
    total++;
    if (rd !== 32'h11223344 || er !== 1'b0) begin
      bad++; $display("FAIL fetch_data got=%h err=%b exp=11223344 err=0", rd, er);
    end
    total++;
    if (cyc != 5 || en != 2) begin
      bad++; $display("FAIL fetch_latency cyc=%0d en=%0d exp cyc=5 en=2", cyc, en);
    end
    mfc_dly = 3;
    i_txn(9'h004, rd, er, cyc, en);
    total++;
    if (rd !== 32'h11223344 || cyc != 7 || en != 4) begin
      bad++; $display("FAIL fetch_slow got=%h cyc=%0d en=%0d exp=11223344 cyc=7 en=4", rd, cyc, en);
    end
    mfc_dly = 1;
  endtask

  task automatic test_byte_rw;
    logic [31:0] rd; logic er; int cyc, en; logic [1:0] sl;
    d_txn(1'b0, 2'd0, 9'h000, 32'hFFFFFF0A, rd, er, cyc, en, sl);
    total++;
    if (er !== 1'b0 || rd !== 32'h0 || sl !== 2'd0) begin
      bad++; $display("FAIL byte_write err=%b rd=%h len=%0d exp err=0 rd=0 len=0", er, rd, sl);
    end
    d_txn(1'b1, 2'd0, 9'h000, 32'h0, rd, er, cyc, en, sl);
    total++;
    if (er !== 1'b0 || rd !== 32'h0000000A || sl !== 2'd0) begin
      bad++; $display("FAIL byte_read err=%b rd=%h len=%0d exp err=0 rd=0000000a len=0", er, rd, sl);
    end
  endtask

  task automatic test_illegal;
    logic [1:0] lens [3];
    logic [8:0] addrs [3];
    logic [31:0] rd; logic er; int cyc, en; logic [1:0] sl;
    lens  = '{2'd1, 2'd3, 2'd2};
    addrs = '{9'h003, 9'h000, 9'h002};
    for (int k = 0; k < 3; k++) begin
      d_txn(1'b1, lens[k], addrs[k], 32'h0, rd, er, cyc, en, sl);
      total++;
      if (er !== 1'b1 || rd !== 32'h0 || cyc != 2 || en != 0) begin
        bad++; $display("FAIL illegal_%0d err=%b rd=%h cyc=%0d en=%0d exp err=1 rd=0 cyc=2 en=0",
                        k, er, rd, cyc, en);
      end
    end
  endtask

  task automatic test_round_robin;
    logic exp_port; int n, dn, inn, cyc;
    reset = 1'b1; #2; @(posedge clk); #1 reset = 1'b0;
    i_addr = 9'h004; d_rw = 1'b1; d_len = 2'd2; d_addr = 9'h010;
    i_req = 1'b1; d_req = 1'b1;
    n = 0; dn = 0; inn = 0; cyc = 0;
    while (n < 6 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      exp_port = (n % 2 == 0);  // 1 = D: D wins first after reset, then alternate
      if (ram_enable) begin
        total++;
        if ({ram_address, ram_read_write, ram_data_length} !==
            (exp_port ? {9'h010, 1'b1, 2'd2} : {9'h004, 1'b1, 2'd2})) begin
          bad++; $display("FAIL rr_ram_req n=%0d addr=%h exp port %s", n, ram_address,
                          exp_port ? "D" : "I");
        end
      end
      if (i_ready || d_ready) begin
        total++;
        if (i_ready === d_ready || d_ready !== exp_port || cyc != 5 * (n + 1)) begin
          bad++; $display("FAIL rr_order n=%0d i_ready=%b d_ready=%b cyc=%0d exp port %s cyc=%0d",
                          n, i_ready, d_ready, cyc, exp_port ? "D" : "I", 5 * (n + 1));
        end
        if (d_ready) begin dn++; if (dn == 3) d_req = 1'b0; end
        if (i_ready) begin inn++; if (inn == 3) i_req = 1'b0; end
        n++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    total++;
    if (n != 6) begin
      bad++; $display("FAIL rr_count got=%0d exp=6", n);
    end
  endtask

  task automatic test_timeout;
    logic [31:0] rd; logic er; int cyc, en; logic [1:0] sl;
    mfc_off = 1'b1;
    d_txn(1'b1, 2'd2, 9'h008, 32'h0, rd, er, cyc, en, sl);
    total++;
    if (en != 16 || er !== 1'b1 || rd !== 32'h0 || cyc != 19) begin
      bad++; $display("FAIL timeout en=%0d err=%b rd=%h cyc=%0d exp en=16 err=1 rd=0 cyc=19",
                      en, er, rd, cyc);
    end
    mfc_off = 1'b0;
    d_txn(1'b1, 2'd2, 9'h004, 32'h0, rd, er, cyc, en, sl);
    total++;
    if (rd !== 32'h11223344 || er !== 1'b0 || cyc != 5) begin
      bad++; $display("FAIL after_timeout rd=%h err=%b cyc=%0d exp=11223344 err=0 cyc=5", rd, er, cyc);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int cyc, en;
    mfc_off = 1'b1;
    i_addr = 9'h004; i_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ram_enable !== 1'b1) begin
      bad++; $display("FAIL mid_access_enable got=%b exp=1", ram_enable);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({ram_enable, i_ready, d_ready, i_err, d_err} !== 5'b0) begin
      bad++; $display("FAIL async_reset got=%b exp=00000", {ram_enable, i_ready, d_ready, i_err, d_err});
    end
    i_req = 1'b0; mfc_off = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    i_txn(9'h004, rd, er, cyc, en);
    total++;
    if (rd !== 32'h11223344 || er !== 1'b0 || cyc != 5) begin
      bad++; $display("FAIL post_reset_fetch rd=%h err=%b cyc=%0d exp=11223344 err=0 cyc=5", rd, er, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_byte_rw();
    test_illegal();
    test_timeout();
    test_round_robin();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
